// File: rtl/i2s_pkg.sv
// Shared constants, FSM encoding and helpers for the oversampling I2S receiver.
package i2s_pkg;

    localparam int I2S_MODE_PHILIPS = 0;
    localparam int I2S_MODE_LEFT    = 1;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RX
    } rx_state_t;

    // Number of BCLK ticks between the LRCK edge and the MSB of a slot.
    function automatic int i2s_lead(input int mode);
        return (mode == I2S_MODE_PHILIPS) ? 1 : 0;
    endfunction

endpackage

// File: rtl/i2s_pin_sync.sv
// Multi-stage synchroniser for one asynchronous codec pin, with rising and
// any-edge strobes derived from the synchronised level.
module i2s_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic toggle
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level  = sync_q[STAGES-1];
    assign rise   = level & ~prev_q;
    assign toggle = level ^ prev_q;

endmodule

// File: rtl/i2s_rx_stream.sv
// I2S / left-justified stereo receiver oversampling the codec pins on clk and
// delivering L/R pairs on a valid/ready stream. Optional I2S_RX_STREAM_FRAME_ERR_EN.
module i2s_rx_stream
    import i2s_pkg::*;
#(
    parameter int DATA_BITS   = 16,
    parameter int SLOT_MAX    = 32,
    parameter int JUSTIFY     = I2S_MODE_PHILIPS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 codec_aud_bclk_i,
    input  logic                 codec_aud_adclrck_i,
    input  logic                 codec_aud_adcdat_i,
    input  logic                 enable_i,
    output logic [DATA_BITS-1:0] sample_L_o,
    output logic [DATA_BITS-1:0] sample_R_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 overrun_o
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
    ,
    output logic                 frame_err_o
`endif
);

    localparam int CW       = $clog2(SLOT_MAX + 1);
    localparam int LEAD     = i2s_lead(JUSTIFY);
    localparam int MIN_SLOT = LEAD + DATA_BITS;
    localparam logic [DATA_BITS-1:0] MSB_ONE = {1'b1, {(DATA_BITS-1){1'b0}}};

    logic tick, lrck_s, dat_s;
    logic bclk_lvl_unused, bclk_any_unused, lrck_rise_unused, lrck_any_unused;
    logic [SYNC_STAGES-1:0] dat_sync;

    i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk(clk), .rst(rst), .pin(codec_aud_bclk_i),
        .level(bclk_lvl_unused), .rise(tick), .toggle(bclk_any_unused)
    );

    i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk(clk), .rst(rst), .pin(codec_aud_adclrck_i),
        .level(lrck_s), .rise(lrck_rise_unused), .toggle(lrck_any_unused)
    );

    // Same depth as the other pins so DAT stays aligned with the BCLK tick.
    always_ff @(posedge clk) begin
        if (rst) dat_sync <= '0;
        else     dat_sync <= {dat_sync[SYNC_STAGES-2:0], codec_aud_adcdat_i};
    end
    assign dat_s = dat_sync[SYNC_STAGES-1];

    rx_state_t              state;
    logic                   lrck_last;
    logic [CW-1:0]          bit_cnt, idx;
    logic [DATA_BITS-1:0]   word, word_nxt, win_mask, hold_l, pend_l, pend_r;
    logic                   lr_edge, l2r, r2l, in_win, pend;
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
    logic                   slot_bad;
`endif

    always_comb begin
        lr_edge = tick && (lrck_s != lrck_last);
        l2r     = lr_edge && lrck_s;
        r2l     = lr_edge && !lrck_s;
        if (lr_edge)                        idx = '0;
        else if (bit_cnt == CW'(SLOT_MAX))  idx = bit_cnt;
        else                                idx = bit_cnt + 1'b1;
        in_win   = (int'(idx) >= LEAD) && (int'(idx) < LEAD + DATA_BITS);
        win_mask = MSB_ONE >> (idx - CW'(LEAD));
        word_nxt = lr_edge ? '0 : word;
        if (in_win)
            word_nxt = dat_s ? (word_nxt | win_mask) : (word_nxt & ~win_mask);
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
        // bit_cnt still holds the last index of the slot that is closing.
        slot_bad = (int'(bit_cnt) + 1 < MIN_SLOT) || (bit_cnt == CW'(SLOT_MAX));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lrck_last  <= 1'b0;
            bit_cnt    <= '0;
            word       <= '0;
            hold_l     <= '0;
            pend       <= 1'b0;
            pend_l     <= '0;
            pend_r     <= '0;
            sample_L_o <= '0;
            sample_R_o <= '0;
            valid_o    <= 1'b0;
            overrun_o  <= 1'b0;
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
            frame_err_o <= 1'b0;
`endif
        end else begin
            pend      <= 1'b0;
            overrun_o <= 1'b0;
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
            frame_err_o <= 1'b0;
`endif
            if (tick) begin
                lrck_last <= lrck_s;
                bit_cnt   <= idx;
                word      <= word_nxt;
            end

            case (state)
                IDLE: if (enable_i) state <= SYNC;
                SYNC: begin
                    if (!enable_i) state <= IDLE;
                    else if (r2l)  state <= RX;
                end
                RX: begin
                    if (!enable_i) state <= IDLE;
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
                    else if (lr_edge && slot_bad) begin
                        state       <= SYNC;
                        frame_err_o <= 1'b1;
                    end
`endif
                    else if (l2r) hold_l <= word;
                    else if (r2l) begin
                        pend   <= 1'b1;
                        pend_l <= hold_l;
                        pend_r <= word;
                    end
                end
                default: state <= IDLE;
            endcase

            // A finished pair either replaces a consumed/empty output or is dropped.
            if (pend && (!valid_o || ready_i)) begin
                sample_L_o <= pend_l;
                sample_R_o <= pend_r;
                valid_o    <= 1'b1;
            end else begin
                if (pend)              overrun_o <= 1'b1;
                if (valid_o && ready_i) valid_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_stream.sv
// Directed bench: a bit-level codec model drives three receiver variants
// (I2S 16-bit, left-justified 16-bit, I2S 24-bit) sharing the same pins.
`timescale 1ns/1ps
module tb_i2s_rx_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bclk = 1'b0, lrck = 1'b1, dat = 1'b0, enable = 1'b0, ready = 1'b1;
    logic [15:0] d_l, d_r, j_l, j_r;
    logic [23:0] w_l, w_r;
    logic d_v, j_v, w_v, d_ov, j_ov, w_ov;
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
    logic d_fe, j_fe, w_fe;
    int   fe_d, fe_j, fe_w;
`endif

    always #5 clk = ~clk;

    i2s_rx_stream #(.DATA_BITS(16), .SLOT_MAX(32), .JUSTIFY(0), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .codec_aud_bclk_i(bclk), .codec_aud_adclrck_i(lrck),
        .codec_aud_adcdat_i(dat), .enable_i(enable), .sample_L_o(d_l), .sample_R_o(d_r),
        .valid_o(d_v), .ready_i(ready), .overrun_o(d_ov)
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
        , .frame_err_o(d_fe)
`endif
    );

    i2s_rx_stream #(.DATA_BITS(16), .SLOT_MAX(32), .JUSTIFY(1), .SYNC_STAGES(2)) u_lj (
        .clk(clk), .rst(rst), .codec_aud_bclk_i(bclk), .codec_aud_adclrck_i(lrck),
        .codec_aud_adcdat_i(dat), .enable_i(enable), .sample_L_o(j_l), .sample_R_o(j_r),
        .valid_o(j_v), .ready_i(ready), .overrun_o(j_ov)
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
        , .frame_err_o(j_fe)
`endif
    );

    i2s_rx_stream #(.DATA_BITS(24), .SLOT_MAX(32), .JUSTIFY(0), .SYNC_STAGES(3)) u_wide (
        .clk(clk), .rst(rst), .codec_aud_bclk_i(bclk), .codec_aud_adclrck_i(lrck),
        .codec_aud_adcdat_i(dat), .enable_i(enable), .sample_L_o(w_l), .sample_R_o(w_r),
        .valid_o(w_v), .ready_i(ready), .overrun_o(w_ov)
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
        , .frame_err_o(w_fe)
`endif
    );

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
    } pair_t;

    pair_t q_d[$], q_j[$], q_w[$];
    int    ov_d, ov_j, ov_w;
    int    n_run = 0, n_fail = 0;

    // Inputs change 1 ns after posedge, so negedge sees the ready used at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (d_v && ready) q_d.push_back({24'(d_l), 24'(d_r)});
            if (j_v && ready) q_j.push_back({24'(j_l), 24'(j_r)});
            if (w_v && ready) q_w.push_back({w_l, w_r});
            if (d_ov) ov_d++;
            if (j_ov) ov_j++;
            if (w_ov) ov_w++;
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
            if (d_fe) fe_d++;
            if (j_fe) fe_j++;
            if (w_fe) fe_w++;
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        q_d.delete(); q_j.delete(); q_w.delete();
        ov_d = 0; ov_j = 0; ov_w = 0;
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
        fe_d = 0; fe_j = 0; fe_w = 0;
`endif
    endtask

    // One BCLK period (8 clk): data/LRCK change with the falling edge.
    task automatic bit_out(input logic lr, input logic d);
        lrck = lr; dat = d;
        step(4);
        bclk = 1'b1;
        step(4);
        bclk = 1'b0;
    endtask

    task automatic send_slot(input logic lr, input logic [15:0] w, input int n, input logic lj);
        for (int i = 0; i < n; i++) begin
            int          k;
            logic [15:0] sh;
            k  = lj ? i : i - 1;
            sh = w << k;
            bit_out(lr, (k >= 0 && k < 16) ? sh[15] : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int n, input logic lj);
        send_slot(1'b0, l, n, lj);
        send_slot(1'b1, r, n, lj);
    endtask

    task automatic preamble();
        send_slot(1'b1, 16'h0, 4, 1'b0);
    endtask

    // A single left-slot tick supplies the R->L edge that completes the last frame.
    task automatic close_frame();
        bit_out(1'b0, 1'b0);
        step(8);
    endtask

    task automatic restart(input logic rdy);
        enable = 1'b0;
        step(4);
        clear_counts();
        ready  = rdy;
        enable = 1'b1;
        step(2);
    endtask

    typedef struct {
        logic        lj;
        logic [15:0] l, r, d_l, d_r, j_l, j_r;
    } vec_t;

    vec_t tv[4];

    initial begin
        // {stream is LJ, L, R, expected I2S-rx L/R, expected LJ-rx L/R}
        tv[0] = '{1'b0, 16'hA5C3, 16'h1234, 16'hA5C3, 16'h1234, 16'h52E1, 16'h091A};
        tv[1] = '{1'b1, 16'hA5C3, 16'h1234, 16'h4B86, 16'h2468, 16'hA5C3, 16'h1234};
        tv[2] = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h0000};
        tv[3] = '{1'b1, 16'h8000, 16'h7FFE, 16'h0000, 16'hFFFC, 16'h8000, 16'h7FFE};
        clear_counts();

        step(4);
        chk("rst_sample_L", 32'(d_l), 32'h0);
        chk("rst_sample_R", 32'(d_r), 32'h0);
        chk("rst_valid", 32'(d_v), 32'h0);
        chk("rst_overrun", 32'(d_ov), 32'h0);
        chk("rst_valid_wide", 32'(w_v), 32'h0);
        rst = 1'b0;
        step(2);

        // Table: both justification modes into both receiver variants.
        restart(1'b1);
        preamble();
        for (int i = 0; i < 4; i++) send_frame(tv[i].l, tv[i].r, 32, tv[i].lj);
        close_frame();
        chk("tbl_count_i2s", 32'(q_d.size()), 32'd4);
        chk("tbl_count_lj", 32'(q_j.size()), 32'd4);
        chk("tbl_no_overrun", 32'(ov_d), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tbl%0d_i2s_L", i), 32'((q_d.size() > i) ? q_d[i].l : 24'hDEAD), 32'(tv[i].d_l));
            chk($sformatf("tbl%0d_i2s_R", i), 32'((q_d.size() > i) ? q_d[i].r : 24'hDEAD), 32'(tv[i].d_r));
            chk($sformatf("tbl%0d_lj_L", i), 32'((q_j.size() > i) ? q_j[i].l : 24'hDEAD), 32'(tv[i].j_l));
            chk($sformatf("tbl%0d_lj_R", i), 32'((q_j.size() > i) ? q_j[i].r : 24'hDEAD), 32'(tv[i].j_r));
        end

        // Backpressure across two completed pairs.
        restart(1'b0);
        preamble();
        send_frame(16'hBEEF, 16'hCAFE, 32, 1'b0);
        send_frame(16'h0F0F, 16'hF0F0, 32, 1'b0);
        close_frame();
        chk("ovr_pulses", 32'(ov_d), 32'd1);
        chk("ovr_pulses_lj", 32'(ov_j), 32'd1);
        chk("ovr_held_valid", 32'(d_v), 32'd1);
        chk("ovr_held_L", 32'(d_l), 32'hBEEF);
        chk("ovr_held_R", 32'(d_r), 32'hCAFE);
        ready = 1'b1;
        step(1);
        chk("ovr_drain_valid", 32'(d_v), 32'd0);
        chk("ovr_drain_count", 32'(q_d.size()), 32'd1);
        chk("ovr_drain_L", 32'((q_d.size() > 0) ? q_d[0].l : 24'hDEAD), 32'hBEEF);

        // Enable mid left slot: the interrupted frame is skipped.
        enable = 1'b0;
        step(4);
        clear_counts();
        preamble();
        fork
            send_frame(16'h1111, 16'h2222, 32, 1'b0);
            begin
                step(8 * 10);
                enable = 1'b1;
            end
        join
        send_frame(16'h3C3C, 16'hC3C3, 32, 1'b0);
        close_frame();
        chk("en_mid_count", 32'(q_d.size()), 32'd1);
        chk("en_mid_L", 32'((q_d.size() > 0) ? q_d[0].l : 24'hDEAD), 32'h3C3C);
        chk("en_mid_R", 32'((q_d.size() > 0) ? q_d[0].r : 24'hDEAD), 32'hC3C3);
        // Disable mid right slot: that pair never appears.
        fork
            send_frame(16'h5555, 16'h6666, 32, 1'b0);
            begin
                step(8 * 42);
                enable = 1'b0;
            end
        join
        close_frame();
        chk("dis_mid_count", 32'(q_d.size()), 32'd1);
        chk("dis_mid_valid", 32'(d_v), 32'd0);

        // 16-tick slots into the 24-bit receiver, then a normal frame.
        restart(1'b1);
        preamble();
        send_frame(16'hA5C3, 16'h1234, 16, 1'b0);
        send_frame(16'hA5C3, 16'h1234, 32, 1'b0);
        close_frame();
`ifdef I2S_RX_STREAM_FRAME_ERR_EN
        chk("short_frame_err", 32'(fe_w), 32'd1);
        chk("short_frame_err_i2s16", 32'(fe_d), 32'd1);
        chk("exact_len_no_err", 32'(fe_j), 32'd0);
        chk("short_err_count", 32'(q_w.size()), 32'd1);
        chk("recover_L", 32'((q_w.size() > 0) ? q_w[0].l : 24'hDEAD), 32'hA5C300);
        chk("recover_R", 32'((q_w.size() > 0) ? q_w[0].r : 24'hDEAD), 32'h123400);
`else
        chk("short_count", 32'(q_w.size()), 32'd2);
        chk("short_pad_L", 32'((q_w.size() > 0) ? q_w[0].l : 24'hDEAD), 32'hA5C200);
        chk("short_pad_R", 32'((q_w.size() > 0) ? q_w[0].r : 24'hDEAD), 32'h123400);
        chk("full_L", 32'((q_w.size() > 1) ? q_w[1].l : 24'hDEAD), 32'hA5C300);
        chk("full_R", 32'((q_w.size() > 1) ? q_w[1].r : 24'hDEAD), 32'h123400);
`endif

        // Reset pulse during RX with a held pair.
        restart(1'b0);
        preamble();
        send_frame(16'h1357, 16'h2468, 32, 1'b0);
        close_frame();
        chk("pre_rst_valid", 32'(d_v), 32'd1);
        fork
            send_frame(16'h9999, 16'h8888, 32, 1'b0);
            begin
                step(8 * 8);
                rst = 1'b1;
                step(1);
                chk("mid_rst_valid", 32'(d_v), 32'd0);
                chk("mid_rst_L", 32'(d_l), 32'h0);
                chk("mid_rst_R", 32'(d_r), 32'h0);
                chk("mid_rst_overrun", 32'(d_ov), 32'h0);
                rst   = 1'b0;
                ready = 1'b1;
            end
        join
        send_frame(16'h0246, 16'h8ACE, 32, 1'b0);
        close_frame();
        chk("post_rst_count", 32'(q_d.size()), 32'd1);
        chk("post_rst_L", 32'((q_d.size() > 0) ? q_d[0].l : 24'hDEAD), 32'h0246);
        chk("post_rst_R", 32'((q_d.size() > 0) ? q_d[0].r : 24'hDEAD), 32'h8ACE);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
